// File: rtl/ahb_pkg.sv
// Shared AHB definitions: htrans encodings and the write-master FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_WAIT_RDY  = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ADDR      = 3'd2,
        ST_ADDR_DATA = 3'd3,
        ST_DATA      = 3'd4
    } ahb_state_e;

    // True in the states that present a NONSEQ address phase on the bus.
    function automatic logic is_addr_phase(ahb_state_e s);
        return (s == ST_ADDR) || (s == ST_ADDR_DATA);
    endfunction

endpackage

// File: rtl/ahb_req_fifo.sv
// Request FIFO for the AHB write master; depth must be a power of two so the
// pointers wrap naturally. A push while full is accepted only with a same-cycle pop.
module ahb_req_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ahb_master_wr.sv
// Pipelined AHB-Lite single-write master fed by a request FIFO.
// Optional AHB_MASTER_WR_STATS_EN adds a 32-bit completed-write counter (wr_count).
// Request side: a request transfers on a rising edge where req_valid && req_ready;
// req_ready depends only on registered state, never on hready.
module ahb_master_wr
    import ahb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int fifoDepth = 4
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [addrWidth-1:0] req_addr,
    input  logic [dataWidth-1:0] req_data,
    output logic                 hselx,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    output logic                 busy,
`ifdef AHB_MASTER_WR_STATS_EN
    output logic [31:0]          wr_count,
`endif
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(fifoDepth) + 1;
    localparam int EW = addrWidth + dataWidth;

    ahb_state_e           state;
    ahb_state_e           state_nxt;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [EW-1:0]        head;
    logic [addrWidth-1:0] head_addr;
    logic [dataWidth-1:0] head_data;
    logic                 addr_done;
    logic                 data_done;
    logic                 more_after_pop;

    assign head_addr      = head[EW-1 -: addrWidth];
    assign head_data      = head[dataWidth-1:0];
    assign fifo_push      = req_valid && req_ready;
    assign addr_done      = is_addr_phase(state) && hready;
    assign data_done      = ((state == ST_ADDR_DATA) || (state == ST_DATA)) && hready;
    assign fifo_pop       = addr_done;
    // Another entry remains once the current head is popped (a same-cycle push counts).
    assign more_after_pop = (fifo_count > CW'(1)) || fifo_push;
    assign dbg_state      = state;

    ahb_req_fifo #(
        .width (EW),
        .depth (fifoDepth)
    ) u_fifo (
        .hclk    (hclk),
        .hresetn (hresetn),
        .push    (fifo_push),
        .wdata   ({req_addr, req_data}),
        .pop     (fifo_pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_WAIT_RDY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_RDY:  if (hready) state_nxt = ST_IDLE;
            ST_IDLE:      if (!fifo_empty) state_nxt = ST_ADDR;
            ST_ADDR,
            ST_ADDR_DATA: if (hready) state_nxt = more_after_pop ? ST_ADDR_DATA : ST_DATA;
            ST_DATA:      if (hready) state_nxt = fifo_empty ? ST_IDLE : ST_ADDR;
            default:      state_nxt = ST_WAIT_RDY;
        endcase
    end

    always_comb begin
        htrans    = HTRANS_IDLE;
        hselx     = 1'b0;
        hwrite    = 1'b0;
        haddr     = '0;
        if (is_addr_phase(state)) begin
            htrans = HTRANS_NONSEQ;
            hselx  = 1'b1;
            hwrite = 1'b1;
            haddr  = head_addr;
        end
        req_ready = (state != ST_WAIT_RDY) && !fifo_full;
        busy      = ((state != ST_IDLE) && (state != ST_WAIT_RDY)) || (fifo_count != '0);
    end

    // Write data is captured as the address phase completes and held through wait states.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)       hwdata <= '0;
        else if (addr_done) hwdata <= head_data;
    end

`ifdef AHB_MASTER_WR_STATS_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)       wr_count <= '0;
        else if (data_done) wr_count <= wr_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ahb_master_wr.sv
// Directed plus randomized bench for ahb_master_wr with an AHB slave model that
// records completed writes; a standalone FIFO instance covers push+pop when full.
module tb_ahb_master_wr;
    import ahb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          hselx;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic          hready = 1'b1;
    logic          busy;
    logic [2:0]    dbg_state;
`ifdef AHB_MASTER_WR_STATS_EN
    logic [31:0]   wr_count;
`endif

    // standalone FIFO
    logic       f_push = 1'b0;
    logic       f_pop = 1'b0;
    logic [7:0] f_wdata = '0;
    logic [7:0] f_rdata;
    logic       f_full;
    logic       f_empty;
    logic [2:0] f_count;

    always #5 hclk = ~hclk;

    ahb_master_wr #(.addrWidth(AW), .dataWidth(DW), .fifoDepth(DEPTH)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hselx     (hselx),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hready    (hready),
        .busy      (busy),
`ifdef AHB_MASTER_WR_STATS_EN
        .wr_count  (wr_count),
`endif
        .dbg_state (dbg_state)
    );

    ahb_req_fifo #(.width(8), .depth(4)) u_fifo (
        .hclk    (hclk),
        .hresetn (hresetn),
        .push    (f_push),
        .wdata   (f_wdata),
        .pop     (f_pop),
        .rdata   (f_rdata),
        .full    (f_full),
        .empty   (f_empty),
        .count   (f_count)
    );

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] obs_q[$];
    logic [DW-1:0]    slave_mem [256];

    // Slave model: address phase on an hready edge, data captured on the next hready edge.
    logic          pend_v;
    logic [AW-1:0] pend_a;
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend_v <= 1'b0;
            pend_a <= '0;
        end else if (hready) begin
            if (pend_v) begin
                obs_q.push_back({pend_a, hwdata});
                slave_mem[pend_a] <= hwdata;
            end
            pend_v <= (htrans == 2'b10);
            pend_a <= haddr;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge hclk);
    endtask

    // Offer a request for the next edge; the model records it if the handshake completes.
    task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        if (req_ready) begin
            exp_q.push_back({a, d});
            accepted++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        req_valid = 1'b0;
        hready    = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk($sformatf("%s_drain_busy", tag), 64'(busy), 64'd0);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        chk($sformatf("%s_write_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_write_%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0]    s_tr [12];
        logic [AW-1:0] s_ad [12];
        logic [DW-1:0] s_wd [12];
        logic [DW-1:0] bd [4];
        logic [1:0]    snap_tr;
        logic [AW-1:0] snap_ad;
        logic [DW-1:0] snap_wd;
        logic          pre_hr;
        logic [1:0]    pre_tr;
        logic [AW-1:0] pre_ad;
        int            k;
        int            nseen;
        bit            stalled;

        // reset values
        repeat (2) step();
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_hselx", 64'(hselx), 64'd0);
        chk("rst_hwrite", 64'(hwrite), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_hwdata", 64'(hwdata), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_WAIT_RDY));
        hresetn = 1'b1;
        step();
        chk("wait_exit_req_ready", 64'(req_ready), 64'd1);
        chk("wait_exit_htrans", 64'(htrans), 64'd0);

        // single request
        offer(8'h10, 32'hCAFE0001);
        step();
        req_valid = 1'b0;
        chk("single_queued_htrans", 64'(htrans), 64'd0);
        chk("single_queued_busy", 64'(busy), 64'd1);
        step();
        chk("single_nonseq", 64'(htrans), 64'd2);
        chk("single_haddr", 64'(haddr), 64'h10);
        chk("single_hselx", 64'(hselx), 64'd1);
        chk("single_hwrite", 64'(hwrite), 64'd1);
        step();
        chk("single_data_htrans", 64'(htrans), 64'd0);
        chk("single_hwdata", 64'(hwdata), 64'hCAFE0001);
        chk("single_data_hselx", 64'(hselx), 64'd0);
        step();
        chk("single_done_busy", 64'(busy), 64'd0);
        compare_queues("single");

        // four back-to-back requests
        for (int i = 0; i < 4; i++) bd[i] = $urandom;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) offer(AW'(i), bd[i]);
            else req_valid = 1'b0;
            step();
            s_tr[i] = htrans;
            s_ad[i] = haddr;
            s_wd[i] = hwdata;
        end
        k = -1;
        for (int i = 11; i >= 0; i--) if (s_tr[i] == 2'b10) k = i;
        chk("b2b_window", 64'(k >= 0 && k + 4 < 12), 64'd1);
        if (k >= 0 && k + 4 < 12) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("b2b_htrans_%0d", j), 64'(s_tr[k+j]), 64'd2);
                chk($sformatf("b2b_haddr_%0d", j), 64'(s_ad[k+j]), 64'(j));
                chk($sformatf("b2b_hwdata_%0d", j), 64'(s_wd[k+j+1]), 64'(bd[j]));
            end
            chk("b2b_end_idle", 64'(s_tr[k+4]), 64'd0);
        end
        drain("b2b");
        for (int j = 0; j < 4; j++)
            chk($sformatf("b2b_mem_%0d", j), 64'(slave_mem[j]), 64'(bd[j]));
        compare_queues("b2b");

        // three-cycle stall in the middle of a burst
        nseen = 0;
        stalled = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) offer(AW'(8'h20 + c), $urandom);
            else req_valid = 1'b0;
            step();
            if (htrans == 2'b10) nseen++;
            if (nseen == 2 && !stalled) begin
                stalled = 1;
                snap_tr = htrans;
                snap_ad = haddr;
                snap_wd = hwdata;
                req_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    hready = 1'b0;
                    step();
                    chk($sformatf("stall_htrans_%0d", s), 64'(htrans), 64'(snap_tr));
                    chk($sformatf("stall_haddr_%0d", s), 64'(haddr), 64'(snap_ad));
                    chk($sformatf("stall_hwdata_%0d", s), 64'(hwdata), 64'(snap_wd));
                end
                hready = 1'b1;
            end
        end
        chk("stall_seen", 64'(stalled), 64'd1);
        drain("stall");
        compare_queues("stall");

        // fill with hready low; the fifth offer must be refused
        hready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(AW'(8'h40 + i), $urandom);
            chk($sformatf("fill_ready_%0d", i), 64'(req_ready), 64'(i < DEPTH));
            step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fill_hold_haddr_%0d", i), 64'(haddr), 64'h40);
            chk($sformatf("fill_hold_htrans_%0d", i), 64'(htrans), 64'd2);
        end
        chk("fill_ready_full", 64'(req_ready), 64'd0);
        drain("fill");
        compare_queues("fill");

        // standalone FIFO: push+pop while full, then pointer wrap
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_wdata = 8'hA0 + 8'(i);
            step();
        end
        f_push = 1'b0;
        chk("fifo_full", 64'(f_full), 64'd1);
        chk("fifo_count_full", 64'(f_count), 64'd4);
        f_push = 1'b1;
        f_pop = 1'b1;
        f_wdata = 8'hA4;
        step();
        f_push = 1'b0;
        f_pop = 1'b0;
        chk("fifo_pushpop_count", 64'(f_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo_order_%0d", i), 64'(f_rdata), 64'(8'hA1 + i));
            f_pop = 1'b1;
            step();
        end
        f_pop = 1'b0;
        chk("fifo_empty", 64'(f_empty), 64'd1);

        // reset asserted while a transfer is in ADDR_DATA
        nseen = 0;
        for (int c = 0; c < 10 && nseen < 2; c++) begin
            if (c < 3) offer(AW'(8'h60 + c), $urandom);
            else req_valid = 1'b0;
            step();
            if (htrans == 2'b10) nseen++;
        end
        chk("pre_rst_state", 64'(dbg_state), 64'(ST_ADDR_DATA));
        req_valid = 1'b0;
        hresetn = 1'b0;
        #1;
        chk("mid_rst_htrans", 64'(htrans), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_hselx", 64'(hselx), 64'd0);
        chk("mid_rst_hwdata", 64'(hwdata), 64'd0);
        chk("mid_rst_fifo", 64'(dut.fifo_empty), 64'd1);
`ifdef AHB_MASTER_WR_STATS_EN
        chk("mid_rst_wr_count", 64'(wr_count), 64'd0);
`endif
        exp_q.delete();
        obs_q.delete();
        accepted = 0;
        step();
        hresetn = 1'b1;
        step();

        // randomized traffic with random wait states
        for (int c = 0; c < 400; c++) begin
            hready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) offer(AW'($urandom), $urandom);
            else req_valid = 1'b0;
            pre_hr = hready;
            pre_tr = htrans;
            pre_ad = haddr;
            step();
            chk("rnd_hselx", 64'(hselx), 64'(htrans == 2'b10));
            chk("rnd_hwrite", 64'(hwrite), 64'(htrans == 2'b10));
            chk("rnd_htrans_legal", 64'(htrans == 2'b00 || htrans == 2'b10), 64'd1);
            if (!pre_hr && pre_tr == 2'b10) begin
                chk("rnd_hold_htrans", 64'(htrans), 64'(pre_tr));
                chk("rnd_hold_haddr", 64'(haddr), 64'(pre_ad));
            end
        end
        drain("rnd");
`ifdef AHB_MASTER_WR_STATS_EN
        chk("rnd_wr_count", 64'(wr_count), 64'(accepted));
`endif
        compare_queues("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
